// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RISC-V control path:
//   - opcode_e      : base-ISA major opcodes (shared with the ALU)
//   - op_class_e    : instruction class produced by riscv_opcode_decode
//   - state_e       : control sequencer states
//   - fault_cause_e : fault code reported when the sequencer halts
//   - operand / write-back / PC-source select encodings
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [6:0] {
        OPC_R     = 7'b0110011,
        OPC_I     = 7'b0010011,
        OPC_LOAD  = 7'b0000011,
        OPC_S     = 7'b0100011,
        OPC_B     = 7'b1100011,
        OPC_JAL   = 7'b1101111,
        OPC_JALR  = 7'b1100111,
        OPC_LUI   = 7'b0110111,
        OPC_AUIPC = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_S       = 4'd3,
        CLS_B       = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } op_class_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_ILLEGAL   = 2'd1,
        FC_IMEM_TO   = 2'd2,
        FC_DMEM_TO   = 2'd3
    } fault_cause_e;

    // ALU operand 1 select
    localparam logic [1:0] IN1_RS1   = 2'd0;
    localparam logic [1:0] IN1_PC    = 2'd1;
    localparam logic [1:0] IN1_UIMM  = 2'd2;

    // ALU operand 2 select
    localparam logic [1:0] IN2_RS2   = 2'd0;
    localparam logic [1:0] IN2_IMM   = 2'd1;
    localparam logic [1:0] IN2_UIMM  = 2'd2;
    localparam logic [1:0] IN2_FOUR  = 2'd3;

    // Register-file write-back source
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_LOAD   = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    // addi x0,x0,0 -- the IR holds this after reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when the destination register field selects a writable register
    function automatic logic rd_writable(input logic [4:0] rd);
        return (rd != 5'd0);
    endfunction

endpackage

// File: rtl/riscv_control_fsm_if.sv
// ---------------------------------------------------------------------------
// riscv_control_fsm_if
// Instruction/data memory handshake bundle between the control sequencer
// (master) and the memory side (slave).
//   imem_rdata  32  fetched instruction word          (slave -> master)
//   imem_valid   1  imem_rdata valid this cycle        (slave -> master)
//   imem_req     1  instruction fetch request          (master -> slave)
//   dmem_req     1  data access request                (master -> slave)
//   dmem_we      1  1 = store, 0 = load (with dmem_req)(master -> slave)
//   dmem_ready   1  data access complete this cycle    (slave -> master)
// ---------------------------------------------------------------------------
interface riscv_control_fsm_if;

    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        input  imem_rdata,
        input  imem_valid,
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        output imem_rdata,
        output imem_valid,
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );

endinterface

// File: rtl/riscv_opcode_decode.sv
// ---------------------------------------------------------------------------
// riscv_opcode_decode
// Combinational classification of the IR major opcode.
//   opcode_i    7  ir[6:0]
//   op_class_o  4  instruction class (CLS_ILLEGAL for unsupported opcodes)
//   legal_o     1  opcode belongs to the supported base-ISA set
// ---------------------------------------------------------------------------
module riscv_opcode_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  op_class_o,
    output logic       legal_o
);

    // Map the major opcode to its class; anything unlisted is illegal
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        legal_o    = 1'b1;
        case (opcode_i)
            OPC_R:     op_class_o = CLS_R;
            OPC_I:     op_class_o = CLS_I;
            OPC_LOAD:  op_class_o = CLS_LOAD;
            OPC_S:     op_class_o = CLS_S;
            OPC_B:     op_class_o = CLS_B;
            OPC_JAL:   op_class_o = CLS_JAL;
            OPC_JALR:  op_class_o = CLS_JALR;
            OPC_LUI:   op_class_o = CLS_LUI;
            OPC_AUIPC: op_class_o = CLS_AUIPC;
            default: begin
                op_class_o = CLS_ILLEGAL;
                legal_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_control_fsm.sv
// ---------------------------------------------------------------------------
// riscv_control_fsm
// Multi-cycle control sequencer for the single-ALU RISC-V core. Steps each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, latches the IR and
// drives ALU selects, register-file/PC strobes and memory requests. Halts
// with a sticky fault code on illegal opcodes or memory handshake timeouts.
//
// Parameters
//   MEM_TIMEOUT  wait cycles allowed in FETCH/MEM before fault (0 = never)
//   CNT_W        width of instret_count_o
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   bus (master)      imem/dmem handshake bundle
//   alu_branch_hit_i  branch condition true
//   ir_o              latched instruction
//   alu_in1_sel_o     0=rs1 1=pc 2=U-imm
//   alu_in2_sel_o     0=rs2 1=I/S-imm 2=U-imm 3=const 4
//   wb_sel_o          0=alu 1=load data 2=pc+4
//   rf_we_o           register-file write strobe (never for rd=x0)
//   pc_we_o, pc_src_o PC write strobe; 0=pc+4 1=pc+B/J-imm 2=alu&~1
//   retire_o          one-cycle pulse per completed instruction
//   instret_count_o   retired-instruction counter (wraps)
//   fault_o           sticky halt flag
//   fault_cause_o     0=none 1=illegal 2=imem timeout 3=dmem timeout
// ---------------------------------------------------------------------------
module riscv_control_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_control_fsm_if.master  bus,
    input  logic                 alu_branch_hit_i,
    output logic [31:0]          ir_o,
    output logic [1:0]           alu_in1_sel_o,
    output logic [1:0]           alu_in2_sel_o,
    output logic [1:0]           wb_sel_o,
    output logic                 rf_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_src_o,
    output logic                 retire_o,
    output logic [CNT_W-1:0]     instret_count_o,
    output logic                 fault_o,
    output logic [1:0]           fault_cause_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               fault_q, fault_d;
    fault_cause_e       cause_q, cause_d;

    op_class_e          cls_s;
    logic               legal_s;
    logic [WAIT_W-1:0]  wait_inc_s;
    logic               timeout_s;
    logic               is_mem_op_s;

    // Ungated strobes; forced low below while reset is asserted
    logic               imem_req_s;
    logic               dmem_req_s;
    logic               dmem_we_s;
    logic               rf_we_s;
    logic               pc_we_s;
    logic [1:0]         pc_src_s;
    logic               retire_s;

    riscv_opcode_decode u_decode (
        .opcode_i   (ir_q[6:0]),
        .op_class_o (cls_s),
        .legal_o    (legal_s)
    );

    // The timeout fires on the wait cycle that would bring the count up to
    // MEM_TIMEOUT; a handshake in that same cycle is checked first and wins.
    assign wait_inc_s  = wait_q + WAIT_W'(1);
    assign timeout_s   = (MEM_TIMEOUT != 0) && (wait_inc_s == WAIT_W'(MEM_TIMEOUT));
    assign is_mem_op_s = (cls_s == CLS_LOAD) || (cls_s == CLS_S);

    // State, IR, wait counter, retire counter and fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= NOP_INSTR;
            wait_q    <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
            cause_q   <= FC_NONE;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state, IR capture, wait counting and fault capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_rdata;
                    wait_d  = '0;
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    wait_d  = '0;
                    fault_d = 1'b1;
                    cause_d = FC_IMEM_TO;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_inc_s;
                end
            end
            ST_DECODE: begin
                wait_d = '0;
                if (legal_s) begin
                    state_d = ST_EXECUTE;
                end else begin
                    fault_d = 1'b1;
                    cause_d = FC_ILLEGAL;
                    state_d = ST_HALT;
                end
            end
            ST_EXECUTE: begin
                wait_d = '0;
                if (cls_s == CLS_B) begin
                    state_d = ST_FETCH;
                end else if (is_mem_op_s) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    wait_d  = '0;
                    state_d = (cls_s == CLS_S) ? ST_FETCH : ST_WRITEBACK;
                end else if (timeout_s) begin
                    wait_d  = '0;
                    fault_d = 1'b1;
                    cause_d = FC_DMEM_TO;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_inc_s;
                end
            end
            ST_WRITEBACK: begin
                wait_d  = '0;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                wait_d  = '0;
                state_d = ST_HALT;
            end
            default: begin
                wait_d  = '0;
                state_d = ST_FETCH;
            end
        endcase
    end

    // Strobe decode from state and instruction class
    always_comb begin
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        rf_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        pc_src_s   = PC_PLUS4;
        retire_s   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
            end
            ST_EXECUTE: begin
                if (cls_s == CLS_B) begin
                    pc_we_s  = 1'b1;
                    pc_src_s = alu_branch_hit_i ? PC_BRANCH : PC_PLUS4;
                    retire_s = 1'b1;
                end else begin
                    pc_we_s  = 1'b0;
                end
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_s == CLS_S);
                // A store completes in MEM; loads still need write-back
                if (bus.dmem_ready && (cls_s == CLS_S)) begin
                    pc_we_s  = 1'b1;
                    retire_s = 1'b1;
                end else begin
                    pc_we_s  = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                rf_we_s  = rd_writable(ir_q[11:7]);
                pc_we_s  = 1'b1;
                retire_s = 1'b1;
                if (cls_s == CLS_JAL) begin
                    pc_src_s = PC_BRANCH;
                end else if (cls_s == CLS_JALR) begin
                    pc_src_s = PC_JALR;
                end else begin
                    pc_src_s = PC_PLUS4;
                end
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // ALU operand and write-back selects, held from EXECUTE to WRITEBACK
    always_comb begin
        alu_in1_sel_o = IN1_RS1;
        alu_in2_sel_o = IN2_RS2;
        wb_sel_o      = WB_ALU;
        if ((state_q == ST_EXECUTE) || (state_q == ST_MEM) || (state_q == ST_WRITEBACK)) begin
            case (cls_s)
                CLS_I, CLS_LOAD, CLS_S, CLS_JALR: alu_in2_sel_o = IN2_IMM;
                CLS_LUI:   alu_in1_sel_o = IN1_UIMM;
                CLS_AUIPC: begin
                    alu_in1_sel_o = IN1_PC;
                    alu_in2_sel_o = IN2_UIMM;
                end
                CLS_JAL: begin
                    alu_in1_sel_o = IN1_PC;
                    alu_in2_sel_o = IN2_FOUR;
                end
                default: alu_in1_sel_o = IN1_RS1;
            endcase
            if (cls_s == CLS_LOAD) begin
                wb_sel_o = WB_LOAD;
            end else if ((cls_s == CLS_JAL) || (cls_s == CLS_JALR)) begin
                wb_sel_o = WB_PC4;
            end else begin
                wb_sel_o = WB_ALU;
            end
        end else begin
            wb_sel_o = WB_ALU;
        end
    end

    // Retired-instruction counter update
    always_comb begin
        if (retire_s) begin
            instret_d = instret_q + CNT_W'(1'b1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Strobes are suppressed while reset is held so an abandoned
    // instruction never writes the PC or register file
    assign bus.imem_req    = imem_req_s & ~rst;
    assign bus.dmem_req    = dmem_req_s & ~rst;
    assign bus.dmem_we     = dmem_we_s  & ~rst;
    assign rf_we_o         = rf_we_s    & ~rst;
    assign pc_we_o         = pc_we_s    & ~rst;
    assign retire_o        = retire_s   & ~rst;
    assign pc_src_o        = pc_src_s;
    assign ir_o            = ir_q;
    assign instret_count_o = instret_q;
    assign fault_o         = fault_q;
    assign fault_cause_o   = cause_q;

endmodule

// File: tb/tb_riscv_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_riscv_control_fsm
// Self-checking bench: each instruction is expanded by a behavioural model
// into a per-cycle list of (handshake inputs, expected outputs, care mask)
// and replayed against the DUT.
// ---------------------------------------------------------------------------
module tb_riscv_control_fsm;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_S = 3, K_B = 4,
                   K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;
    localparam int TMO = 16;

    // Observed vector layout:
    // [16]imem_req [15]dmem_req [14]dmem_we [13]rf_we [12]pc_we [11:10]pc_src
    // [9:8]wb_sel [7]retire [6:5]in1 [4:3]in2 [2]fault [1:0]cause
    localparam logic [16:0] MB  = 17'b1_1_0_1_1_00_00_1_00_00_1_11;
    localparam logic [16:0] MDW = 17'h04000;
    localparam logic [16:0] MPS = 17'h00C00;
    localparam logic [16:0] MWB = 17'h00300;
    localparam logic [16:0] MI1 = 17'h00060;
    localparam logic [16:0] MI2 = 17'h00018;

    typedef struct packed {
        logic        iv;
        logic        dr;
        logic [16:0] ex;
        logic [16:0] mk;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_hit = 1'b0;
    logic [31:0] ir;
    logic [1:0]  in1, in2, wb_sel, pc_src, cause;
    logic        rf_we, pc_we, retire, fault;
    logic [31:0] instret;
    logic [16:0] obs;

    int          n_vec = 0;
    int          n_err = 0;
    cyc_t        tr[$];
    logic [31:0] exp_ir = 32'h0000_0013;
    int          exp_cnt = 0;
    logic [6:0]  opc_tab [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h6F, 7'h67, 7'h37, 7'h17};

    always #5 clk = ~clk;

    riscv_control_fsm_if bus ();

    riscv_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .alu_branch_hit_i (br_hit),
        .ir_o             (ir),
        .alu_in1_sel_o    (in1),
        .alu_in2_sel_o    (in2),
        .wb_sel_o         (wb_sel),
        .rf_we_o          (rf_we),
        .pc_we_o          (pc_we),
        .pc_src_o         (pc_src),
        .retire_o         (retire),
        .instret_count_o  (instret),
        .fault_o          (fault),
        .fault_cause_o    (cause)
    );

    assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, pc_we, pc_src,
                  wb_sel, retire, in1, in2, fault, cause};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return K_R;
            7'h13:   return K_I;
            7'h03:   return K_LD;
            7'h23:   return K_S;
            7'h63:   return K_B;
            7'h6F:   return K_JAL;
            7'h67:   return K_JALR;
            7'h37:   return K_LUI;
            7'h17:   return K_AUIPC;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [16:0] pk(input bit ireq, input bit dreq, input bit dwe,
                                       input bit rfwe, input bit pcwe, input int ps,
                                       input int wb, input bit rt, input int i1,
                                       input int i2, input bit f, input int c);
        return {ireq, dreq, dwe, rfwe, pcwe, 2'(ps), 2'(wb), rt, 2'(i1), 2'(i2), f, 2'(c)};
    endfunction

    task automatic push(input bit iv, input bit dr, input logic [16:0] ex, input logic [16:0] mk);
        cyc_t e;
        e.iv = iv; e.dr = dr; e.ex = ex; e.mk = mk;
        tr.push_back(e);
    endtask

    task automatic push_halt(input int c);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,1,c), MB);
    endtask

    // Behavioural expansion of one instruction into its expected cycles
    task automatic model(input logic [31:0] w, input int fdel, input int ddel, input bit hit,
                         output bit ret, output bit halted);
        int k, i1, i2, wbv, psv;
        bit st, rw;
        logic [16:0] sm;
        tr.delete();
        ret = 1'b0; halted = 1'b0;
        k   = classify(w);
        i1  = (k == K_AUIPC || k == K_JAL) ? 1 : (k == K_LUI) ? 2 : 0;
        i2  = (k == K_R || k == K_B) ? 0 : (k == K_AUIPC) ? 2 : (k == K_JAL) ? 3 : 1;
        wbv = (k == K_LD) ? 1 : (k == K_JAL || k == K_JALR) ? 2 : 0;
        psv = (k == K_JAL) ? 1 : (k == K_JALR) ? 2 : 0;
        st  = (k == K_S);
        rw  = (w[11:7] != 5'd0);
        sm  = MB | MI1 | ((k == K_LUI) ? 17'h0 : MI2);
        if (fdel >= TMO) begin
            for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,0,0), MB);
            push_halt(2); halted = 1'b1; return;
        end
        for (int i = 0; i < fdel; i++) push(1'b0, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,0,0), MB);
        push(1'b1, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,0,0), MB);
        push(1'b0, 1'b0, 17'h0, MB);
        if (k == K_ILL) begin
            push_halt(1); halted = 1'b1; return;
        end
        if (k == K_B) begin
            push(1'b0, 1'b0, pk(0,0,0,0,1,int'(hit),0,1,i1,i2,0,0), sm | MPS);
            ret = 1'b1; return;
        end
        push(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,i1,i2,0,0), sm);
        if (k == K_LD || k == K_S) begin
            if (ddel >= TMO) begin
                for (int i = 0; i < TMO; i++)
                    push(1'b0, 1'b0, pk(0,1,st,0,0,0,0,0,i1,i2,0,0), sm | MDW);
                push_halt(3); halted = 1'b1; return;
            end
            for (int i = 0; i < ddel; i++)
                push(1'b0, 1'b0, pk(0,1,st,0,0,0,0,0,i1,i2,0,0), sm | MDW);
            push(1'b0, 1'b1, pk(0,1,st,0,st,0,0,st,i1,i2,0,0), sm | MDW | (st ? MPS : 17'h0));
            if (st) begin
                ret = 1'b1; return;
            end
        end
        push(1'b0, 1'b0, pk(0,0,0,rw,1,psv,wbv,1,i1,i2,0,0), sm | MPS | MWB);
        ret = 1'b1;
    endtask

    // Replay the expected cycles; starts and ends just after a rising edge
    task automatic play(input logic [31:0] w, input bit hit, input int limit, input string nm);
        bus.imem_rdata = w;
        br_hit = hit;
        for (int c = 0; c < tr.size() && c < limit; c++) begin
            bus.imem_valid = tr[c].iv;
            bus.dmem_ready = tr[c].dr;
            @(negedge clk);
            check_val($sformatf("%s c%0d", nm, c), 32'(obs & tr[c].mk), 32'(tr[c].ex & tr[c].mk));
            @(posedge clk);
            #1;
        end
        bus.imem_valid = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_strobes", 32'(obs & MB), 32'h0);
        check_val("rst_ir", ir, 32'h0000_0013);
        check_val("rst_instret", instret, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rst_fetch_req", 32'(bus.imem_req), 32'h1);
        exp_cnt = 0;
        exp_ir  = 32'h0000_0013;
    endtask

    task automatic run_one(input logic [31:0] w, input int fdel, input int ddel,
                           input bit hit, input string nm);
        bit ret, halted;
        model(w, fdel, ddel, hit, ret, halted);
        play(w, hit, 100000, nm);
        if (fdel < TMO) exp_ir = w;
        if (ret) exp_cnt++;
        check_val({nm, " ir"}, ir, exp_ir);
        check_val({nm, " instret"}, instret, 32'(exp_cnt));
        if (halted) do_reset();
    endtask

    initial begin
        bit          ret, halted;
        logic [31:0] w;
        int          k, fd, dd;
        bus.imem_rdata = 32'h0;
        bus.imem_valid = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_one(32'h00500093, 0, 0, 1'b0, "addi");
        run_one(32'h00002103, 0, 3, 1'b0, "lw");
        run_one(32'h00000463, 0, 0, 1'b1, "beq_hit");
        run_one(32'h00000463, 0, 0, 1'b0, "beq_miss");
        run_one(32'h000000EF, 0, 0, 1'b0, "jal");
        run_one(32'h00000013, 15, 0, 1'b0, "imem_edge");
        run_one(32'h00112023, 0, 15, 1'b0, "dmem_edge");
        run_one(32'hFFFFFFFF, 0, 0, 1'b0, "illegal");
        run_one(32'h00000013, 16, 0, 1'b0, "imem_tmo");
        run_one(32'h00112023, 0, 16, 1'b0, "dmem_tmo");
        run_one(32'h00500093, 0, 0, 1'b0, "pre_abort");

        // Store abandoned by reset while waiting in MEM
        model(32'h00112023, 0, 10, 1'b0, ret, halted);
        play(32'h00112023, 1'b0, 5, "abort");
        do_reset();

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            w = $urandom;
            if (k == K_ILL) begin
                while (classify(w) != K_ILL) w = $urandom;
            end else begin
                w[6:0] = opc_tab[k];
            end
            fd = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 2);
            dd = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 2);
            run_one(w, fd, dd, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
